// File: rtl/command_dispatcher.sv
// command_dispatcher: turns a 2-byte UART frame (address, request) into a decoder dispatch
module command_dispatcher #(
  parameter int NUM_DEVICES  = 1,
  parameter int BYTE_TIMEOUT = 5000000,
  parameter int RESP_TIMEOUT = 10000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        finished,
  output logic        enable,
  output logic [31:0] device_selector,
  output logic [7:0]  request,
  output logic        busy,
  output logic        frame_error,
  output logic        timeout_error,
  output logic        overrun
);
  localparam logic [27:0] BYTE_LAST = 28'(BYTE_TIMEOUT - 1);
  localparam logic [27:0] RESP_LAST = 28'(RESP_TIMEOUT - 1);
  typedef enum logic [1:0] {WAIT_ADDR, WAIT_CMD, WAIT_DONE} state_t;
  state_t state, next_state;
  logic [4:0] addr, addr_d;
  logic addr_ok, addr_ok_d;
  logic [27:0] byte_cnt, byte_cnt_d, resp_cnt, resp_cnt_d;
  logic enable_d, busy_d, frame_error_d, timeout_error_d, overrun_d;
  logic [31:0] device_selector_d;
  logic [7:0] request_d;
  logic byte_last, resp_last;
  assign byte_last = byte_cnt == BYTE_LAST;
  assign resp_last = resp_cnt == RESP_LAST;
  // state, counters and all registered outputs; reset drops enable immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= WAIT_ADDR;
      addr            <= '0;
      addr_ok         <= 1'b0;
      byte_cnt        <= '0;
      resp_cnt        <= '0;
      enable          <= 1'b0;
      busy            <= 1'b0;
      request         <= '0;
      device_selector <= '0;
      frame_error     <= 1'b0;
      timeout_error   <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      state           <= next_state;
      addr            <= addr_d;
      addr_ok         <= addr_ok_d;
      byte_cnt        <= byte_cnt_d;
      resp_cnt        <= resp_cnt_d;
      enable          <= enable_d;
      busy            <= busy_d;
      request         <= request_d;
      device_selector <= device_selector_d;
      frame_error     <= frame_error_d;
      timeout_error   <= timeout_error_d;
      overrun         <= overrun_d;
    end
  end
  // frame sequencing: a byte always beats a timeout, finished always beats a timeout
  always_comb begin
    next_state = WAIT_ADDR;
    case (state)
      WAIT_ADDR: next_state = rx_valid ? WAIT_CMD : WAIT_ADDR;
      WAIT_CMD:  next_state = (rx_valid && addr_ok) ? WAIT_DONE : (rx_valid || byte_last) ? WAIT_ADDR : WAIT_CMD;
      WAIT_DONE: next_state = (finished || resp_last) ? WAIT_ADDR : WAIT_DONE;
      default:   next_state = WAIT_ADDR;
    endcase
  end
  // next values of outputs and counters; request/device_selector persist after completion
  always_comb begin
    addr_d            = addr;
    addr_ok_d         = addr_ok;
    byte_cnt_d        = byte_cnt;
    resp_cnt_d        = resp_cnt;
    enable_d          = enable;
    busy_d            = busy;
    request_d         = request;
    device_selector_d = device_selector;
    frame_error_d     = 1'b0;
    timeout_error_d   = 1'b0;
    overrun_d         = 1'b0;
    case (state)
      WAIT_ADDR: begin
        if (rx_valid) begin
          addr_d     = rx_data[4:0];
          addr_ok_d  = {24'd0, rx_data} < 32'(NUM_DEVICES);
          byte_cnt_d = '0;
        end
      end
      WAIT_CMD: begin
        byte_cnt_d    = byte_last ? byte_cnt : byte_cnt + 28'd1;
        frame_error_d = rx_valid ? !addr_ok : byte_last;
        if (rx_valid && addr_ok) begin
          request_d         = rx_data;
          device_selector_d = 32'd1 << addr;
          enable_d          = 1'b1;
          busy_d            = 1'b1;
          resp_cnt_d        = '0;
        end
      end
      WAIT_DONE: begin
        resp_cnt_d      = resp_last ? resp_cnt : resp_cnt + 28'd1;
        timeout_error_d = !finished && resp_last;
        overrun_d       = rx_valid;
        if (finished || resp_last) begin
          enable_d = 1'b0;
          busy_d   = 1'b0;
        end
      end
      default: begin
        addr_d = addr;
      end
    endcase
  end
endmodule

// File: tb/tb_command_dispatcher.sv
// tb_command_dispatcher: table vectors, directed corner cases and random traffic vs a reference model
module tb_command_dispatcher;
  localparam int NUM_DEV = 4;
  localparam int BYTE_TO = 16;
  localparam int RESP_TO = 32;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic finished = 1'b0;
  logic enable, busy, frame_error, timeout_error, overrun;
  logic [31:0] device_selector;
  logic [7:0] request;
  int tests = 0;
  int fails = 0;
  int ncyc = 0;
  logic m_busy, m_have, m_fe, m_to, m_ov;
  logic [7:0] m_addr, m_req;
  logic [31:0] m_sel;
  int m_age;
  typedef struct {
    logic v; logic [7:0] d; logic f;
    logic en; logic bsy; logic fe; logic to; logic ov; logic [7:0] req; logic [31:0] sel;
  } vec_t;
  vec_t vecs[22];
  command_dispatcher #(.NUM_DEVICES(NUM_DEV), .BYTE_TIMEOUT(BYTE_TO), .RESP_TIMEOUT(RESP_TO)) dut (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid), .finished(finished),
    .enable(enable), .device_selector(device_selector), .request(request), .busy(busy),
    .frame_error(frame_error), .timeout_error(timeout_error), .overrun(overrun)
  );
  always #5 clock = ~clock;
  function automatic logic [44:0] pk(logic en, logic bs, logic fe, logic to, logic ov, logic [7:0] r, logic [31:0] s);
    return {en, bs, fe, to, ov, r, s};
  endfunction
  function automatic logic [44:0] dut_vec();
    return pk(enable, busy, frame_error, timeout_error, overrun, request, device_selector);
  endfunction
  function automatic logic [44:0] model_vec();
    return pk(m_busy, m_busy, m_fe, m_to, m_ov, m_req, m_sel);
  endfunction
  task automatic check(input string name, input logic [44:0] act, input logic [44:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_have = 0; m_fe = 0; m_to = 0; m_ov = 0;
    m_addr = '0; m_req = '0; m_sel = '0; m_age = 0;
  endtask
  // one clock of the frame protocol, written from the behavioural rules
  task automatic model_step(input logic v, input logic [7:0] d, input logic f);
    m_fe = 0; m_to = 0; m_ov = 0;
    if (m_busy) begin
      m_age++;
      m_ov = v;
      if (f) m_busy = 0;
      else if (m_age == RESP_TO) begin m_busy = 0; m_to = 1; end
    end else if (m_have) begin
      m_age++;
      if (v) begin
        m_have = 0;
        if (int'(m_addr) < NUM_DEV) begin
          m_busy = 1; m_age = 0; m_req = d; m_sel = 32'd1 << m_addr;
        end else m_fe = 1;
      end else if (m_age == BYTE_TO) begin
        m_have = 0; m_fe = 1;
      end
    end else if (v) begin
      m_have = 1; m_addr = d; m_age = 0;
    end
  endtask
  task automatic cycle(input logic v, input logic [7:0] d, input logic f);
    rx_valid = v; rx_data = d; finished = f;
    @(posedge clock);
    model_step(v, d, f);
    #1;
    ncyc++;
    check($sformatf("model cycle %0d", ncyc), dut_vec(), model_vec());
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("async reset", dut_vec(), '0);
    #2;
    reset_n = 1'b1;
    model_reset();
  endtask
  task automatic dispatch(input logic [7:0] a, input logic [7:0] r);
    cycle(1, a, 0);
    cycle(1, r, 0);
  endtask
  initial begin
    vecs[0]  = '{1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0};
    vecs[1]  = '{1, 8'h01, 0, 1, 1, 0, 0, 0, 8'h01, 32'h1};
    vecs[2]  = '{0, 8'h00, 0, 1, 1, 0, 0, 0, 8'h01, 32'h1};
    vecs[3]  = '{0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h01, 32'h1};
    vecs[4]  = '{1, 8'h05, 0, 0, 0, 0, 0, 0, 8'h01, 32'h1};
    vecs[5]  = '{1, 8'h02, 0, 0, 0, 1, 0, 0, 8'h01, 32'h1};
    vecs[6]  = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h01, 32'h1};
    vecs[7]  = '{1, 8'h03, 0, 0, 0, 0, 0, 0, 8'h01, 32'h1};
    vecs[8]  = '{1, 8'h07, 0, 1, 1, 0, 0, 0, 8'h07, 32'h8};
    vecs[9]  = '{1, 8'h03, 0, 1, 1, 0, 0, 1, 8'h07, 32'h8};
    vecs[10] = '{1, 8'h09, 1, 0, 0, 0, 0, 1, 8'h07, 32'h8};
    vecs[11] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h07, 32'h8};
    vecs[12] = '{1, 8'h20, 0, 0, 0, 0, 0, 0, 8'h07, 32'h8};
    vecs[13] = '{1, 8'h01, 0, 0, 0, 1, 0, 0, 8'h07, 32'h8};
    vecs[14] = '{1, 8'h24, 0, 0, 0, 0, 0, 0, 8'h07, 32'h8};
    vecs[15] = '{1, 8'h02, 0, 0, 0, 1, 0, 0, 8'h07, 32'h8};
    vecs[16] = '{1, 8'h04, 0, 0, 0, 0, 0, 0, 8'h07, 32'h8};
    vecs[17] = '{1, 8'h01, 0, 0, 0, 1, 0, 0, 8'h07, 32'h8};
    vecs[18] = '{1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h07, 32'h8};
    vecs[19] = '{1, 8'h08, 0, 1, 1, 0, 0, 0, 8'h08, 32'h1};
    vecs[20] = '{0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h08, 32'h1};
    vecs[21] = '{0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h08, 32'h1};
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset values", dut_vec(), '0);
    reset_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].f);
      check($sformatf("vec %0d", i), dut_vec(),
            pk(vecs[i].en, vecs[i].bsy, vecs[i].fe, vecs[i].to, vecs[i].ov, vecs[i].req, vecs[i].sel));
    end
    cycle(1, 8'h00, 0);
    for (int k = 1; k < BYTE_TO; k++) cycle(0, 8'h00, 0);
    check("byte timeout early", 45'(frame_error), 45'(0));
    cycle(0, 8'h00, 0);
    check("byte timeout pulse", 45'(frame_error), 45'(1));
    cycle(0, 8'h00, 0);
    check("byte timeout pulse width", 45'(frame_error), 45'(0));
    cycle(1, 8'h00, 0);
    for (int k = 1; k < BYTE_TO; k++) cycle(0, 8'h00, 0);
    cycle(1, 8'h02, 0);
    check("rx wins at byte limit", dut_vec(), pk(1, 1, 0, 0, 0, 8'h02, 32'h1));
    for (int k = 1; k < RESP_TO; k++) cycle(0, 8'h00, 0);
    check("resp timeout early", {43'd0, enable, timeout_error}, 45'b10);
    cycle(0, 8'h00, 0);
    check("resp timeout pulse", dut_vec(), pk(0, 0, 0, 1, 0, 8'h02, 32'h1));
    cycle(0, 8'h00, 0);
    check("resp timeout pulse width", 45'(timeout_error), 45'(0));
    dispatch(8'h03, 8'h06);
    for (int k = 1; k < RESP_TO; k++) cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 1);
    check("finished wins at resp limit", dut_vec(), pk(0, 0, 0, 0, 0, 8'h06, 32'h8));
    dispatch(8'h02, 8'h07);
    check("dispatch before reset", dut_vec(), pk(1, 1, 0, 0, 0, 8'h07, 32'h4));
    do_reset();
    cycle(0, 8'h00, 0);
    for (int i = 0; i < 4000; i++) begin
      logic v, f;
      logic [7:0] d;
      if ($urandom_range(0, 599) == 0) do_reset();
      v = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 23) == 0);
      d = $urandom_range(0, 1) ? 8'($urandom_range(0, 5)) : 8'($urandom);
      f = $urandom_range(0, 15) == 0;
      cycle(v, d, f);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/command_dispatcher.md
Name: command_dispatcher

Overview:
- Upstream stage of the sensor decoder.
- Receives a 2-byte command frame (device address, request code) from the UART receiver.
- Drives the decoder's enable / device_selector / request interface and holds enable until the decoder reports finished.
- Covers inter-byte timeout, bad addresses, missing decoder responses and commands arriving while busy.

Parameters:
NUM_DEVICES, 1, number of attached sensors; valid addresses 0..NUM_DEVICES-1 (max 32)
BYTE_TIMEOUT, 5000000, max cycles allowed between address byte and command byte
RESP_TIMEOUT, 10000000, max cycles enable is held high waiting for finished

Ports:
clock  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
rx_data  input  8  byte from UART receiver, valid when rx_valid=1
rx_valid  input  1  one-cycle strobe per received byte
finished  input  1  decoder completion pulse
enable  output  1  decoder start; held high until finished or timeout
device_selector  output  32  one-hot sensor select, bit[address]
request  output  8  request code to decoder; held stable until the next accepted frame
busy  output  1  high while waiting for decoder completion
frame_error  output  1  one-cycle pulse: bad address or inter-byte timeout
timeout_error  output  1  one-cycle pulse: decoder did not finish in time
overrun  output  1  one-cycle pulse: byte dropped while busy

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release): state=WAIT_ADDR; enable=0; device_selector=0; request=8'h00; busy=0; all pulses=0; both counters=0.
- Default every cycle: frame_error, timeout_error and overrun are driven to 0 unless set below.
- WAIT_ADDR: on rx_valid, latch rx_data[4:0] and the range flag (rx_data < NUM_DEVICES, full 8-bit compare); clear byte counter; go to WAIT_CMD.
- WAIT_CMD, byte counter increments each cycle:
  - rx_valid with valid address: request<=rx_data; device_selector<=1<<addr; enable<=1; busy<=1; clear resp counter; go to WAIT_DONE. enable rises the cycle after the command byte strobe.
  - rx_valid with invalid address: frame_error pulse; request and device_selector unchanged; go to WAIT_ADDR.
  - Byte counter reaches BYTE_TIMEOUT-1 without rx_valid: frame_error pulse; go to WAIT_ADDR. If rx_valid arrives on that same cycle, the byte is accepted (rx_valid wins).
- WAIT_DONE, resp counter increments each cycle:
  - finished=1: enable<=0; busy<=0; go to WAIT_ADDR. enable falls the cycle after finished is sampled, so the decoder sees enable=0 when it returns to idle and does not retrigger.
  - Resp counter reaches RESP_TIMEOUT-1 without finished: enable<=0; busy<=0; timeout_error pulse; go to WAIT_ADDR. finished on the same cycle wins: no error.
  - rx_valid: byte discarded; overrun pulse. This applies even on the cycle finished arrives.
- After completion, request and device_selector keep their values. The decoder's monitoring loop reads request without enable. A later frame with code 8'h07/8'h08 therefore reaches the decoder on the cycle after the command byte is accepted, and enable is also asserted.
- Counters are 28 bits, saturate at their limit and are only cleared on state entry.
- Reset mid-frame or mid-dispatch: immediate return to reset values; enable drops asynchronously.
- Unused states return to WAIT_ADDR.

Test Plan:
- Bytes 8'h00 then 8'h01 (NUM_DEVICES=1) -> request=8'h01, device_selector=32'h1, enable=1 one cycle after 2nd strobe. finished pulse -> enable=0 next cycle, busy=0.
- Bytes 8'h05 then 8'h02 with NUM_DEVICES=1 -> frame_error single pulse, enable stays 0, request keeps the previous value.
- Byte 8'h00, no second byte, BYTE_TIMEOUT=16 -> frame_error pulse 16 cycles later; then 8'h00, 8'h02 dispatches normally.
- Valid frame, finished never arrives, RESP_TIMEOUT=32 -> enable high for 32 cycles, then enable=0, timeout_error pulse.
- During WAIT_DONE, send byte 8'h03 -> overrun pulse, request unchanged, the in-flight dispatch completes on finished.
- Frame 00/03, finished; then frame 00/07 -> request=8'h07 one cycle after the 2nd strobe, enable reasserted. Also: assert reset_n=0 while enable=1 -> enable=0 immediately, all outputs at reset values.
